// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file with one write port, two
// registered read ports, write-first bypass and a hardware clear sweep.
//
// Optional build macro: REGFILE_ZERO_REG_EN
//   defined   -> entry 0 is hardwired to zero (writes dropped, reads 0,
//                no bypass on address 0); the sweep still runs DEPTH cycles.
//   undefined -> entry 0 is an ordinary register.
//
// Handshake: there is no valid/ready pair. A write is accepted at a rising
// edge only when the sweep is idle, w=1, clr=0 and wn addresses a real
// entry (and, with the zero register, wn != 0); otherwise it is lost, never
// queued. clr is a single-cycle request accepted only while idle; busy is
// high from the edge after clr until the edge that clears entry DEPTH-1.
//
// Debug: dbg_state_o mirrors the sweep FSM state (0 = IDLE, 1 = SWEEP).

module regfile_2r1w #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w,
  input  logic [ADDR_W-1:0] wn,
  input  logic [WIDTH-1:0]  d,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic              clr,
  output logic [WIDTH-1:0]  qa,
  output logic [WIDTH-1:0]  qb,
  output logic              busy,
  output logic              dbg_state_o
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // Depth as an (ADDR_W+1)-bit value so "address < DEPTH" never overflows,
  // even when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  qa_q, qa_d;
  logic [WIDTH-1:0]  qb_q, qb_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];

  logic              wn_in_range;
  logic              wn_writable;
  logic              wr_en;
  logic [WIDTH-1:0]  rd_a;
  logic [WIDTH-1:0]  rd_b;

  // Write address qualification: real entry, and not the hardwired zero.
  always_comb begin
    wn_in_range = ({1'b0, wn} < DEPTH_C);
    wn_writable = wn_in_range;
    if (ZERO_REG && (wn == '0)) begin
      wn_writable = 1'b0;
    end
  end

  // Sweep FSM next state; also decides whether this edge commits a write.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          // clr wins over a simultaneous write.
          state_d = ST_SWEEP;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end else if (w && wn_writable) begin
          wr_en = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (ptr_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Storage next state: either one accepted write or one swept entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wn == ADDR_W'(i))) begin
        mem_d[i] = d;
      end
      if ((state_q == ST_SWEEP) && (ptr_q == ADDR_W'(i))) begin
        mem_d[i] = '0;
      end
    end
  end

  // Read muxes over stored contents; out-of-range addresses read as zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra == ADDR_W'(i)) begin
        rd_a = mem_q[i];
      end
      if (rb == ADDR_W'(i)) begin
        rd_b = mem_q[i];
      end
    end
    if (ZERO_REG && (ra == '0)) begin
      rd_a = '0;
    end
    if (ZERO_REG && (rb == '0)) begin
      rd_b = '0;
    end
  end

  // Read-port next values with write-first bypass. wr_en is never set in
  // SWEEP or for the zero register, so neither case can bypass.
  always_comb begin
    qa_d = rd_a;
    qb_d = rd_b;
    if (wr_en && (wn == ra)) begin
      qa_d = d;
    end
    if (wr_en && (wn == rb)) begin
      qb_d = d;
    end
  end

  // FSM, pointer and busy flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Register array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qa_q <= '0;
      qb_q <= '0;
    end else begin
      qa_q <= qa_d;
      qb_q <= qb_d;
    end
  end

  assign qa          = qa_q;
  assign qb          = qb_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed testbench for regfile_2r1w. Two instances: the default 8-entry
// build and a 6-entry build used to reach an out-of-range write address.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_regfile_2r1w;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-entry instance
  logic       w = 1'b0, clr = 1'b0;
  logic [2:0] wn = '0, ra = '0, rb = '0;
  logic [7:0] d = '0;
  logic [7:0] qa, qb;
  logic       busy, dbg;

  // 6-entry instance
  logic       w6 = 1'b0, clr6 = 1'b0;
  logic [2:0] wn6 = '0, ra6 = '0, rb6 = '0;
  logic [7:0] d6 = '0;
  logic [7:0] qa6, qb6;
  logic       busy6, dbg6;

  int vec_cnt = 0;
  int err_cnt = 0;

  regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) u_dut (
    .clk(clk), .rst(rst), .w(w), .wn(wn), .d(d), .ra(ra), .rb(rb),
    .clr(clr), .qa(qa), .qb(qb), .busy(busy), .dbg_state_o(dbg)
  );

  regfile_2r1w #(.WIDTH(8), .DEPTH(6), .ADDR_W(3)) u_dut6 (
    .clk(clk), .rst(rst), .w(w6), .wn(wn6), .d(d6), .ra(ra6), .rb(rb6),
    .clr(clr6), .qa(qa6), .qb(qb6), .busy(busy6), .dbg_state_o(dbg6)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; w = 1'b1; wn = 3'd3; d = 8'hA5;
    repeat (6) begin
      #10;
      w = ~w;
      d = ~d;
    end
    vec_cnt++;
    if (qa !== 8'h00 || qb !== 8'h00 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_hold qa=%h qb=%h busy=%b want 00 00 0", qa, qb, busy);
    end
    #2 rst = 1'b0;
    w = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(7 - i); ra6 = 3'(i);
      tick();
      vec_cnt++;
      if (qa !== 8'h00 || qb !== 8'h00 || qa6 !== 8'h00) begin
        err_cnt++;
        $display("FAIL reset_read[%0d] qa=%h qb=%h qa6=%h want 00", i, qa, qb, qa6);
      end
    end
  endtask

  task automatic test_write_read();
    w = 1'b1; wn = 3'd1; d = 8'h11; tick();
    wn = 3'd7; d = 8'hFF; tick();
    w = 1'b0; ra = 3'd1; rb = 3'd7; tick();
    vec_cnt++;
    if (qa !== 8'h11 || qb !== 8'hFF) begin
      err_cnt++;
      $display("FAIL write_read qa=%h qb=%h want 11 ff", qa, qb);
    end
    // swap ports to prove both see the whole array
    ra = 3'd7; rb = 3'd1; tick();
    vec_cnt++;
    if (qa !== 8'hFF || qb !== 8'h11) begin
      err_cnt++;
      $display("FAIL write_read_swap qa=%h qb=%h want ff 11", qa, qb);
    end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 6; i++) begin
      w6 = 1'b1; wn6 = 3'(i); d6 = 8'h60 + 8'(i);
      tick();
    end
    // out-of-range write with a read of the same address on the same edge
    w6 = 1'b1; wn6 = 3'd6; d6 = 8'hEE; ra6 = 3'd6; rb6 = 3'd7;
    tick();
    w6 = 1'b0;
    vec_cnt++;
    if (qa6 !== 8'h00 || qb6 !== 8'h00) begin
      err_cnt++;
      $display("FAIL oor_write_bypass qa6=%h qb6=%h want 00 00", qa6, qb6);
    end
    for (int i = 0; i < 6; i++) begin
      ra6 = 3'(i); rb6 = 3'd6;
      tick();
      vec_cnt++;
      if (qa6 !== (8'h60 + 8'(i)) || qb6 !== 8'h00) begin
        err_cnt++;
        $display("FAIL oor_contents[%0d] qa6=%h qb6=%h want %h 00",
                 i, qa6, qb6, 8'h60 + 8'(i));
      end
    end
  endtask

  task automatic test_bypass();
    w = 1'b1; wn = 3'd2; d = 8'h3C; tick();
    w = 1'b1; wn = 3'd2; d = 8'hC3; ra = 3'd2; rb = 3'd2; tick();
    vec_cnt++;
    if (qa !== 8'hC3 || qb !== 8'hC3) begin
      err_cnt++;
      $display("FAIL bypass_both qa=%h qb=%h want c3 c3", qa, qb);
    end
    // bypass on port B only, port A reads stored entry 2
    w = 1'b1; wn = 3'd3; d = 8'h5E; ra = 3'd2; rb = 3'd3; tick();
    w = 1'b0;
    vec_cnt++;
    if (qa !== 8'hC3 || qb !== 8'h5E) begin
      err_cnt++;
      $display("FAIL bypass_b_only qa=%h qb=%h want c3 5e", qa, qb);
    end
    ra = 3'd3; rb = 3'd2; tick();
    vec_cnt++;
    if (qa !== 8'h5E || qb !== 8'hC3) begin
      err_cnt++;
      $display("FAIL bypass_stored qa=%h qb=%h want 5e c3", qa, qb);
    end
  endtask

  task automatic test_clear_sweep();
    int busy_cycles;
    logic [7:0] exp_a;
    for (int i = 0; i < 8; i++) begin
      w = 1'b1; wn = 3'(i); d = 8'h80 + 8'(i);
      tick();
    end
    // clr together with a write to entry 0: the write must be dropped
    clr = 1'b1; w = 1'b1; wn = 3'd0; d = 8'h55; ra = 3'd5; rb = 3'd0;
    tick();
    clr = 1'b0;
    busy_cycles = 0;
    if (busy === 1'b1) busy_cycles++;
    vec_cnt++;
    if (busy !== 1'b1 || qa !== 8'h85 || qb !== 8'h80) begin
      err_cnt++;
      $display("FAIL sweep_start busy=%b qa=%h qb=%h want 1 85 80", busy, qa, qb);
    end
    // writes during busy are lost; ra=5 watched across its clear
    w = 1'b1; wn = 3'd6; d = 8'hAA; rb = 3'd6;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (busy === 1'b1) busy_cycles++;
      exp_a = (j <= 6) ? 8'h85 : 8'h00;
      vec_cnt++;
      if (qa !== exp_a || busy !== (j < 8) || qb !== ((j <= 7) ? 8'h86 : 8'h00)) begin
        err_cnt++;
        $display("FAIL sweep_step[%0d] qa=%h busy=%b qb=%h want %h %b %h",
                 j, qa, busy, qb, exp_a, (j < 8), (j <= 7) ? 8'h86 : 8'h00);
      end
    end
    vec_cnt++;
    if (busy_cycles != 8) begin
      err_cnt++;
      $display("FAIL sweep_busy_len got=%0d want 8", busy_cycles);
    end
    // first edge after busy falls: write accepted, seen through bypass
    w = 1'b1; wn = 3'd4; d = 8'h42; ra = 3'd4; rb = 3'd6;
    tick();
    w = 1'b0;
    vec_cnt++;
    if (qa !== 8'h42 || qb !== 8'h00) begin
      err_cnt++;
      $display("FAIL post_sweep_write qa=%h qb=%h want 42 00", qa, qb);
    end
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(7 - i);
      tick();
      vec_cnt++;
      if (qa !== ((i == 4) ? 8'h42 : 8'h00) || qb !== ((i == 3) ? 8'h42 : 8'h00)) begin
        err_cnt++;
        $display("FAIL post_sweep_read[%0d] qa=%h qb=%h", i, qa, qb);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    w = 1'b1; wn = 3'd3; d = 8'h33; tick();
    w = 1'b0; clr = 1'b1; tick();
    clr = 1'b0;
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL midrst_busy_on busy=%b want 1", busy);
    end
    tick();
    tick();
    // third busy cycle: async reset must drop busy without a clock edge
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if (busy !== 1'b0 || dbg !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrst_busy_off busy=%b state=%b want 0 0", busy, dbg);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(i);
      tick();
      vec_cnt++;
      if (qa !== 8'h00 || qb !== 8'h00 || busy !== 1'b0) begin
        err_cnt++;
        $display("FAIL midrst_read[%0d] qa=%h qb=%h busy=%b want 00 00 0", i, qa, qb, busy);
      end
    end
    w = 1'b1; wn = 3'd5; d = 8'h99; ra = 3'd0; rb = 3'd0; tick();
    w = 1'b0; ra = 3'd5; tick();
    vec_cnt++;
    if (qa !== 8'h99) begin
      err_cnt++;
      $display("FAIL midrst_readback qa=%h want 99", qa);
    end
  endtask

  task automatic test_zero_reg();
    logic [7:0] exp_z;
    exp_z = ZR ? 8'h00 : 8'h77;
    w = 1'b1; wn = 3'd0; d = 8'h77; ra = 3'd0; rb = 3'd0; tick();
    w = 1'b0;
    vec_cnt++;
    if (qa !== exp_z || qb !== exp_z) begin
      err_cnt++;
      $display("FAIL zero_reg_bypass qa=%h qb=%h want %h", qa, qb, exp_z);
    end
    tick();
    vec_cnt++;
    if (qa !== exp_z) begin
      err_cnt++;
      $display("FAIL zero_reg_stored qa=%h want %h", qa, exp_z);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_bypass();
    test_clear_sweep();
    test_reset_mid_sweep();
    test_zero_reg();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // hard stop so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
